// File: rtl/reg_list_pkg.sv
// -----------------------------------------------------------------------------
// reg_list_pkg
// Shared constants, FSM state type and popcount helper for the LDM/STM
// register-list encoder (reg_list_encoder and its sub-modules).
// -----------------------------------------------------------------------------
package reg_list_pkg;

  localparam int LIST_W = 16;                // one bit per architectural register
  localparam int IDX_W  = $clog2(LIST_W);    // emitted register number width
  localparam int CNT_W  = $clog2(LIST_W + 1); // beat count width (0..LIST_W)

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [CNT_W-1:0] popcount(input logic [LIST_W-1:0] vec);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < LIST_W; i++) begin
      sum = sum + CNT_W'(vec[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/reg_list_encoder_if.sv
// -----------------------------------------------------------------------------
// reg_list_encoder_if
// Bundles the decode-side request, the consumer handshake and the status
// outputs of reg_list_encoder.
//   master : decode stage / consumer side (drives start, reg_list, ready)
//   slave  : the encoder (drives valid, reg_num, first, last, busy, done,
//            empty, count)
// -----------------------------------------------------------------------------
interface reg_list_encoder_if
  import reg_list_pkg::*;
();

  logic              start;
  logic [LIST_W-1:0] reg_list;
  logic              ready;
  logic              valid;
  logic [IDX_W-1:0]  reg_num;
  logic              first;
  logic              last;
  logic              busy;
  logic              done;
  logic              empty;
  logic [CNT_W-1:0]  count;

  modport master (
    output start, reg_list, ready,
    input  valid, reg_num, first, last, busy, done, empty, count
  );

  modport slave (
    input  start, reg_list, ready,
    output valid, reg_num, first, last, busy, done, empty, count
  );

endinterface

// File: rtl/lsb_priority_encoder.sv
// -----------------------------------------------------------------------------
// lsb_priority_encoder
// Combinational LIST_W -> IDX_W finder of the lowest set bit.
// Build option REG_LIST_DESC_EN: the input is bit-reversed and the result
// mirrored, so the module then reports the highest set bit instead.
// An all-zero input yields index 0 (default build) / LIST_W-1 (descending);
// the caller only uses the result while the vector is non-zero.
// Ports:
//   i_vec : LIST_W  vector to search
//   o_idx : IDX_W   index of the selected set bit
// -----------------------------------------------------------------------------
module lsb_priority_encoder
  import reg_list_pkg::*;
(
  input  logic [LIST_W-1:0] i_vec,
  output logic [IDX_W-1:0]  o_idx
);

  logic [LIST_W-1:0] w_vec;
  logic [IDX_W-1:0]  w_idx;

`ifdef REG_LIST_DESC_EN
  assign w_vec = {<<{i_vec}};
  assign o_idx = IDX_W'(LIST_W - 1) - w_idx;
`else
  assign w_vec = i_vec;
  assign o_idx = w_idx;
`endif

  // Scan from the top down so the lowest set bit is the last to write w_idx.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    w_idx = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (w_vec[i]) w_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/reg_list_encoder.sv
// -----------------------------------------------------------------------------
// reg_list_encoder
// Encoder counterpart of the register-file 4-to-16 decoder for LDM/STM.
// Captures a 16-bit register list on start and emits one register number per
// valid/ready beat, then pulses done for one cycle.
// Build option REG_LIST_DESC_EN: emit highest register first (R15 down),
// otherwise lowest register first (ARM LDM/STM order).
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : reg_list_encoder_if.slave
//           in : start, reg_list, ready
//           out: valid, reg_num, first, last, busy, done, empty, count
// -----------------------------------------------------------------------------
module reg_list_encoder
  import reg_list_pkg::*;
(
  input logic               clk,
  input logic               reset,
  reg_list_encoder_if.slave bus
);

  state_e            r_state;
  state_e            w_next;
  logic [LIST_W-1:0] r_pending;
  logic              r_first;
  logic              r_done;
  logic              r_empty;
  logic [CNT_W-1:0]  r_count;

  logic              w_run;
  logic              w_hs;
  logic              w_last;
  logic              w_accept;
  logic [IDX_W-1:0]  w_idx;

  lsb_priority_encoder u_prienc (
    .i_vec (r_pending),
    .o_idx (w_idx)
  );

  assign w_run    = (r_state == RUN);
  assign w_hs     = w_run && bus.ready;
  assign w_last   = w_run && (popcount(r_pending) == CNT_W'(1));
  // start is only honoured from IDLE, which includes the done cycle.
  assign w_accept = (r_state == IDLE) && bus.start;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept && (|bus.reg_list)) w_next = RUN;
      RUN:     if (w_hs && w_last)              w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_first   <= 1'b0;
      r_done    <= 1'b0;
      r_empty   <= 1'b0;
      r_count   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_pending <= bus.reg_list;
        r_count   <= popcount(bus.reg_list);
        r_empty   <= (bus.reg_list == '0);
        r_first   <= 1'b1;
        // An empty list completes immediately without entering RUN.
        if (bus.reg_list == '0) r_done <= 1'b1;
      end else if (w_hs) begin
        // Retire exactly the bit currently presented on reg_num.
        r_pending <= r_pending & ~(LIST_W'(1) << w_idx);
        r_first   <= 1'b0;
        if (w_last) r_done <= 1'b1;
      end
    end
  end

  assign bus.valid   = w_run;
  assign bus.reg_num = w_run ? w_idx : '0;
  assign bus.first   = w_run && r_first;
  assign bus.last    = w_last;
  assign bus.busy    = w_run;
  assign bus.done    = r_done;
  assign bus.empty   = r_empty;
  assign bus.count   = r_count;

endmodule
